// File: rtl/cbfp_pkg.sv
// Shared helpers for the block-floating-point normaliser: sign-bit counting,
// min reduction and drain FSM state encodings.
package cbfp_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Redundant sign bits of the low w bits of x (leading bits equal to the sign, minus one).
    function automatic int unsigned lsc(input logic [63:0] x, input int unsigned w);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int b = 62; b >= 0; b--) begin
            if (b <= int'(w) - 2 && run) begin
                if (x[6'(b)] == x[6'(w - 1)]) n++;
                else run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cbfp_lane_scale.sv
// Combinational scaling of one real value by a signed block shift, with
// optional round-half-up and saturation on right shifts.
module cbfp_lane_scale #(
    parameter int unsigned INPUT_WIDTH  = 25,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned ROUND_MODE   = 0
) (
    input  logic        [INPUT_WIDTH-1:0]         x,
    input  logic signed [$clog2(INPUT_WIDTH):0]   shift,
    output logic        [OUTPUT_WIDTH-1:0]        y_c
);

    localparam int unsigned EXP_W = $clog2(INPUT_WIDTH) + 1;
    localparam int unsigned XW    = INPUT_WIDTH + 1;

    logic        [EXP_W-1:0] amt_c;
    logic signed [XW-1:0]    xe_c;
    logic signed [XW-1:0]    rnd_c;
    logic signed [XW-1:0]    shr_c;
    logic                    ovf_c;

    // One guard bit above the input keeps the rounding add from wrapping.
    always_comb begin
        amt_c = shift[EXP_W-1] ? EXP_W'(-shift) : EXP_W'(shift);
        xe_c  = {x[INPUT_WIDTH-1], x};
        rnd_c = xe_c;
        if (ROUND_MODE != 0 && shift[EXP_W-1]) begin
            rnd_c = xe_c + (XW'(1) << (amt_c - EXP_W'(1)));
        end
        shr_c = rnd_c >>> amt_c;
        ovf_c = shr_c[XW-1:OUTPUT_WIDTH-1] != {(XW-OUTPUT_WIDTH+1){shr_c[XW-1]}};
        if (!shift[EXP_W-1]) begin
            y_c = OUTPUT_WIDTH'(x << amt_c);
        end else if (ROUND_MODE != 0 && ovf_c) begin
            y_c = shr_c[XW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else begin
            y_c = OUTPUT_WIDTH'(shr_c);
        end
    end

endmodule

// File: rtl/cbfp_block_norm.sv
// Convolutional block-floating-point normaliser: ping-pong buffers a block of
// LANES-wide complex beats, finds the block exponent and re-emits it scaled.
module cbfp_block_norm
    import cbfp_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 25,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned LANES        = 8,
    parameter int unsigned BLOCK_BEATS  = 4,
    parameter int unsigned ROUND_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [LANES*INPUT_WIDTH-1:0]       in_re,
    input  logic [LANES*INPUT_WIDTH-1:0]       in_im,
    output logic                               out_valid,
    output logic                               out_last,
    output logic [LANES*OUTPUT_WIDTH-1:0]      out_re,
    output logic [LANES*OUTPUT_WIDTH-1:0]      out_im,
    output logic signed [$clog2(INPUT_WIDTH):0] out_exp
);

    localparam int unsigned DIFF   = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam int unsigned LSC_W  = $clog2(INPUT_WIDTH);
    localparam int unsigned EXP_W  = LSC_W + 1;
    localparam int unsigned CNT_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int unsigned WORD_W = 2 * LANES * INPUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_BEATS - 1);
    localparam logic [LSC_W-1:0] LSC_INIT  = LSC_W'(INPUT_WIDTH - 1);

    logic [WORD_W-1:0] mem [2][BLOCK_BEATS];

    logic [CNT_W-1:0]       wr_cnt;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [0:0]             state_q, state_d;
    logic                   bank;
    logic                   rd_bank;
    logic [LSC_W-1:0]       run_min;
    logic [LSC_W-1:0]       blk_min;
    logic [LSC_W-1:0]       beat_min_c;
    logic [LSC_W-1:0]       merged_min_c;
    logic                   blk_close_c;
    logic [WORD_W-1:0]      rd_word_c;
    logic signed [EXP_W-1:0] shift_c;
    logic [LANES*OUTPUT_WIDTH-1:0] scl_re_c;
    logic [LANES*OUTPUT_WIDTH-1:0] scl_im_c;

    // Minimum redundant-sign count across every value of the incoming beat.
    always_comb begin
        int unsigned m;
        m = INPUT_WIDTH - 1;
        for (int i = 0; i < int'(LANES); i++) begin
            m = umin(m, lsc(64'(in_re[i*INPUT_WIDTH +: INPUT_WIDTH]), INPUT_WIDTH));
            m = umin(m, lsc(64'(in_im[i*INPUT_WIDTH +: INPUT_WIDTH]), INPUT_WIDTH));
        end
        beat_min_c = LSC_W'(m);
    end

    assign merged_min_c = LSC_W'(umin(32'(run_min), 32'(beat_min_c)));
    assign blk_close_c  = in_valid && (wr_cnt == LAST_BEAT);

    // Fill side: write pointer, bank select and running block minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            bank    <= 1'b0;
            rd_bank <= 1'b0;
            run_min <= LSC_INIT;
            blk_min <= LSC_INIT;
        end else if (in_valid) begin
            if (blk_close_c) begin
                wr_cnt  <= '0;
                run_min <= LSC_INIT;
                blk_min <= merged_min_c;
                rd_bank <= bank;
                bank    <= ~bank;
            end else begin
                wr_cnt  <= wr_cnt + CNT_W'(1);
                run_min <= merged_min_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[bank][wr_cnt] <= {in_im, in_re};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Drain sequencing; a block closing on the final drain beat restarts at once.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_close_c) begin
                    state_d  = ST_DRAIN;
                    rd_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (rd_cnt_q == LAST_BEAT) begin
                    rd_cnt_d = '0;
                    if (!blk_close_c) state_d = ST_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_cnt_d = '0;
            end
        endcase
    end

    assign rd_word_c = mem[rd_bank][rd_cnt_q];
    assign shift_c   = $signed(EXP_W'(blk_min)) - $signed(EXP_W'(DIFF));

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        cbfp_lane_scale #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .OUTPUT_WIDTH(OUTPUT_WIDTH),
            .ROUND_MODE  (ROUND_MODE)
        ) u_re (
            .x    (rd_word_c[i*INPUT_WIDTH +: INPUT_WIDTH]),
            .shift(shift_c),
            .y_c  (scl_re_c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
        );
        cbfp_lane_scale #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .OUTPUT_WIDTH(OUTPUT_WIDTH),
            .ROUND_MODE  (ROUND_MODE)
        ) u_im (
            .x    (rd_word_c[(LANES+i)*INPUT_WIDTH +: INPUT_WIDTH]),
            .shift(shift_c),
            .y_c  (scl_im_c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_exp   <= '0;
        end else begin
            out_valid <= (state_q == ST_DRAIN);
            out_last  <= (state_q == ST_DRAIN) && (rd_cnt_q == LAST_BEAT);
            if (state_q == ST_DRAIN) begin
                out_re  <= scl_re_c;
                out_im  <= scl_im_c;
                out_exp <= -shift_c;
            end
        end
    end

endmodule

// File: doc/cbfp_block_norm.md
Name: cbfp_block_norm

Overview:
Parametrised convolutional block-floating-point normaliser for the FFT datapath; successor to the fixed 8-lane, single-beat CBFP stage.
- Accepts LANES complex samples per beat. A block spans BLOCK_BEATS beats.
- Finds the minimum redundant-sign-bit count over the whole block, then re-emits the block scaled to OUTPUT_WIDTH with a shared block exponent.
- Ping-pong buffered, so a continuous 1-beat/cycle input stream is sustained.
- Adds valid/last framing, exponent output, selectable rounding and saturation.

Parameters:
INPUT_WIDTH, 25, signed input sample width.
OUTPUT_WIDTH, 12, signed output width; must be <= INPUT_WIDTH.
LANES, 8, complex samples per beat.
BLOCK_BEATS, 4, beats per block; >= 1.
ROUND_MODE, 0, 0 = truncate (arithmetic floor), 1 = round-half-up with saturation.
Derived localparams:
- DIFF = INPUT_WIDTH-OUTPUT_WIDTH.
- LSC_W = $clog2(INPUT_WIDTH).
- EXP_W = LSC_W+1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input beat valid
in_re  in  LANES x INPUT_WIDTH signed  real parts
in_im  in  LANES x INPUT_WIDTH signed  imaginary parts
out_valid  out  1  output beat valid
out_last  out  1  last beat of an output block
out_re  out  LANES x OUTPUT_WIDTH signed  normalised real parts
out_im  out  LANES x OUTPUT_WIDTH signed  normalised imaginary parts
out_exp  out  EXP_W signed  block exponent; true value = out * 2^out_exp

Behaviour:
- Reset (async, rst=1):
  - Outputs: out_valid=0, out_last=0, out_re/out_im=0, out_exp=0.
  - Internal state cleared: wr_cnt, rd_cnt, bank, running min (= INPUT_WIDTH-1), FSM=IDLE.
  - Reset mid-block discards the partial input block and any block being drained.
- LSC(x):
  - Count of leading bits equal to the sign bit, minus 1; range 0..INPUT_WIDTH-1.
  - x=0 and x=-1 give INPUT_WIDTH-1.
- Fill side:
  - Each cycle with in_valid=1, the beat is written to buffer[bank][wr_cnt].
  - beat_min = min LSC over all 2*LANES values; running min updates to min(running, beat_min).
  - wr_cnt increments and wraps at BLOCK_BEATS-1. Gaps in in_valid hold wr_cnt and the running min.
- Block close: on the edge accepting beat BLOCK_BEATS-1:
  - blk_min = min(running, beat_min) is registered into the exponent register.
  - Running min resets to INPUT_WIDTH-1, bank toggles, and the drain FSM enters DRAIN with rd_cnt=0.
- Drain FSM:
  - States: IDLE -> DRAIN on block close.
  - DRAIN emits one beat per cycle regardless of in_valid. At rd_cnt=BLOCK_BEATS-1 it goes to IDLE, or restarts at rd_cnt=0 if a new block closes on that same edge.
  - Filling a block takes >= BLOCK_BEATS cycles, so the draining bank is never overwritten; no overflow state exists.
- Latency: the last input beat sampled at the end of cycle n gives output beat 0 valid in cycle n+2. Outputs are registered.
- out_last = 1 on output beat BLOCK_BEATS-1. out_exp holds the block exponent for all beats of the block.
- Scaling: s = blk_min - DIFF (signed); out_exp = -s.
  - s >= 0: out = x << s, keeping the low OUTPUT_WIDTH bits. This cannot overflow by construction.
  - s < 0: out = x >>> (-s).
    - ROUND_MODE=1: add 2^(-s-1) before the shift, then saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- All-zero block: blk_min = INPUT_WIDTH-1, outputs 0, out_exp = -(OUTPUT_WIDTH-1).
- BLOCK_BEATS=1: every valid beat closes a block, and back-to-back blocks stream with no bubbles.

Decomposition:
- Package cbfp_pkg:
  - lsc function, parametrised by width.
  - min-reduce function.
  - Drain FSM state enum {IDLE, DRAIN}.
- Sub-module cbfp_lane_scale: one real value, combinational shift/round/saturate, instantiated 2*LANES times.
- Buffer, counters and FSM live in the top module.

Test Plan:
All tests use defaults unless stated (INPUT_WIDTH=25, OUTPUT_WIDTH=12, LANES=8, BLOCK_BEATS=4).
- Max |x| = 1000 in block (all others 500):
  - Expected: blk_min=14, s=+1. Outputs 2000 / 1000, out_exp=-1.
  - Beat 0 out_valid exactly 2 cycles after the 4th input beat; out_last on beat 3.
- One value 2^20, others 3: s=-10, out 1024 and 0, out_exp=10.
- Block max 4095, other value 3, includes -4096:
  - ROUND_MODE=0: outputs 2047, 1, -2048.
  - ROUND_MODE=1: outputs 2047 (saturated), 2, -2048.
  - out_exp=1 in both modes.
- Continuous in_valid for 3 blocks with different maxima:
  - out_valid stays high for 12 cycles with no gaps.
  - Each block carries its own out_exp; no cross-bank corruption.
- in_valid toggling 1-0-1-0 within a block: wr_cnt holds during gaps; output identical to the gap-free case.
- All-zero block: outputs 0, out_exp=-11.
- rst asserted after 2 beats, then a fresh block: no output from the partial block; the new block is correct.
